// File: rtl/cv32e40p_perm_fault_detector_ft.sv
// Leaky-bucket permanent-fault classifier per ALU/MULT replica; latency 1 cycle, all outputs registered.
// No backpressure: a vote is consumed in the cycle it is valid; counting pauses while fewer than 3 replicas are eligible.
module cv32e40p_perm_fault_detector_ft #(
    parameter int CNT_W     = 6,
    parameter int INC       = 4,
    parameter int DEC       = 1,
    parameter int THRESHOLD = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_vote_valid_i,
    input  logic [3:0]         alu_active_i,
    input  logic [3:0]         alu_err_i,
    input  logic               mult_vote_valid_i,
    input  logic [2:0]         mult_active_i,
    input  logic [2:0]         mult_err_i,
    input  logic [3:0]         clear_alu_i,
    input  logic [2:0]         clear_mult_i,
    output logic [3:0]         permanent_faulty_alu_o,
    output logic [2:0]         permanent_faulty_mult_o,
    output logic               new_fault_o,
    output logic [4*CNT_W-1:0] alu_cnt_o,
    output logic [3*CNT_W-1:0] mult_cnt_o
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0] INC_W   = (CNT_W+1)'(INC);
    localparam logic [CNT_W:0] DEC_W   = (CNT_W+1)'(DEC);
    localparam logic [CNT_W:0] TH_W    = (CNT_W+1)'(THRESHOLD);

    logic [4*CNT_W-1:0] alu_cnt_q, alu_cnt_d;
    logic [3*CNT_W-1:0] mult_cnt_q, mult_cnt_d;
    logic [3:0]         alu_flag_q, alu_flag_d, alu_elig, alu_rise;
    logic [2:0]         mult_flag_q, mult_flag_d, mult_elig, mult_rise;
    logic               alu_en, mult_en, new_fault_q;

    // Saturating add on error, floored subtract on agreement; sum kept one bit wider.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt, input logic err);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + INC_W;
        if (err)
            next_cnt = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
        else
            next_cnt = ({1'b0, cnt} >= DEC_W) ? (cnt - DEC_W[CNT_W-1:0]) : '0;
    endfunction

    always_comb begin
        alu_elig  = {4{alu_vote_valid_i}} & alu_active_i & ~alu_flag_q;
        alu_en    = ($countones(alu_elig) >= 3);
        alu_cnt_d = alu_cnt_q;
        alu_flag_d = alu_flag_q;
        alu_rise  = '0;
        for (int i = 0; i < 4; i++) begin
            if (clear_alu_i[i]) begin
                alu_cnt_d[i*CNT_W +: CNT_W] = '0;
                alu_flag_d[i] = 1'b0;
            end else if (alu_en && alu_elig[i]) begin
                alu_cnt_d[i*CNT_W +: CNT_W] = next_cnt(alu_cnt_q[i*CNT_W +: CNT_W], alu_err_i[i]);
                if ({1'b0, next_cnt(alu_cnt_q[i*CNT_W +: CNT_W], alu_err_i[i])} >= TH_W) begin
                    alu_flag_d[i] = 1'b1;
                    alu_rise[i]   = 1'b1;
                end
            end
        end
    end

    // MULT has only three replicas, so all of them must be eligible to count.
    always_comb begin
        mult_elig   = {3{mult_vote_valid_i}} & mult_active_i & ~mult_flag_q;
        mult_en     = ($countones(mult_elig) >= 3);
        mult_cnt_d  = mult_cnt_q;
        mult_flag_d = mult_flag_q;
        mult_rise   = '0;
        for (int i = 0; i < 3; i++) begin
            if (clear_mult_i[i]) begin
                mult_cnt_d[i*CNT_W +: CNT_W] = '0;
                mult_flag_d[i] = 1'b0;
            end else if (mult_en && mult_elig[i]) begin
                mult_cnt_d[i*CNT_W +: CNT_W] = next_cnt(mult_cnt_q[i*CNT_W +: CNT_W], mult_err_i[i]);
                if ({1'b0, next_cnt(mult_cnt_q[i*CNT_W +: CNT_W], mult_err_i[i])} >= TH_W) begin
                    mult_flag_d[i] = 1'b1;
                    mult_rise[i]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_cnt_q   <= '0;
            mult_cnt_q  <= '0;
            alu_flag_q  <= '0;
            mult_flag_q <= '0;
            new_fault_q <= 1'b0;
        end else begin
            alu_cnt_q   <= alu_cnt_d;
            mult_cnt_q  <= mult_cnt_d;
            alu_flag_q  <= alu_flag_d;
            mult_flag_q <= mult_flag_d;
            new_fault_q <= |{alu_rise, mult_rise};
        end
    end

    assign permanent_faulty_alu_o  = alu_flag_q;
    assign permanent_faulty_mult_o = mult_flag_q;
    assign new_fault_o             = new_fault_q;
    assign alu_cnt_o               = alu_cnt_q;
    assign mult_cnt_o              = mult_cnt_q;

endmodule
